// File: rtl/wb_arbiter_nx1_if.sv
// wb_arbiter_nx1_if: requester-side and shared slave-side Wishbone signals of the N:1 arbiter
interface wb_arbiter_nx1_if #(
  parameter int N_MASTERS     = 4,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32
);
  localparam int SW = WB_DATA_WIDTH / 8;
  logic [N_MASTERS-1:0][WB_ADDR_WIDTH-1:0] m_adr;
  logic [N_MASTERS-1:0][WB_DATA_WIDTH-1:0] m_dat_w;
  logic [N_MASTERS-1:0][SW-1:0]            m_sel;
  logic [N_MASTERS-1:0][2:0]               m_cti;
  logic [N_MASTERS-1:0][1:0]               m_bte;
  logic [N_MASTERS-1:0]                    m_cyc, m_stb, m_we, m_ack, m_err, grant;
  logic [WB_DATA_WIDTH-1:0]                m_dat_r, s_dat_w, s_dat_r;
  logic [WB_ADDR_WIDTH-1:0]                s_adr;
  logic [SW-1:0]                           s_sel;
  logic [2:0]                              s_cti;
  logic [1:0]                              s_bte;
  logic                                    s_cyc, s_stb, s_we, s_ack, s_err, timeout_evt;
  modport master (
    input  m_adr, m_dat_w, m_sel, m_cti, m_bte, m_cyc, m_stb, m_we, s_dat_r, s_ack, s_err,
    output m_dat_r, m_ack, m_err, s_adr, s_dat_w, s_sel, s_cti, s_bte, s_cyc, s_stb, s_we,
           grant, timeout_evt
  );
  modport slave (
    output m_adr, m_dat_w, m_sel, m_cti, m_bte, m_cyc, m_stb, m_we, s_dat_r, s_ack, s_err,
    input  m_dat_r, m_ack, m_err, s_adr, s_dat_w, s_sel, s_cti, s_bte, s_cyc, s_stb, s_we,
           grant, timeout_evt
  );
endinterface

// File: rtl/wb_arbiter_nx1.sv
// wb_arbiter_nx1: round-robin N:1 Wishbone arbiter with per-cycle ownership and ACK/ERR watchdog
module wb_arbiter_nx1 #(
  parameter int N_MASTERS     = 4,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int TIMEOUT       = 256
) (
  input logic               clk,
  input logic               rst,
  wb_arbiter_nx1_if.master  bus
);
  localparam int IW = $clog2(N_MASTERS);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, pick, idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          evt_q, evt_d, own_cyc, stall, wd_hit;
  always_comb begin
    pick = last_q;
    idx  = '0;
    for (int i = N_MASTERS; i >= 1; i--) begin
      idx = IW'((int'(last_q) + i) % N_MASTERS);
      if (bus.m_cyc[idx]) pick = idx;
    end
  end
  assign own_cyc = bus.m_cyc[grant_q];
  assign stall   = state_q == BUSY && bus.m_stb[grant_q] && !bus.s_ack && !bus.s_err;
  assign wd_hit  = TIMEOUT > 0 && stall && cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (state_q == IDLE && |bus.m_cyc) begin
      state_d = BUSY;
      grant_d = pick;
      last_d  = pick;
    end else if (state_q != IDLE && !own_cyc) state_d = IDLE;
    else if (wd_hit) state_d = ABORT;
    cnt_d = (TIMEOUT > 0 && stall && state_d == BUSY) ? CW'(cnt_q + 1'b1) : '0;
    evt_d = state_q == BUSY && state_d == ABORT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(N_MASTERS - 1);
      cnt_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end
  // Slave side is only connected in BUSY; late responses in IDLE/ABORT are dropped here.
  always_comb begin
    bus.m_dat_r = bus.s_dat_r;
    bus.m_ack   = '0;
    bus.m_err   = '0;
    bus.grant   = '0;
    bus.s_adr   = '0;
    bus.s_dat_w = '0;
    bus.s_sel   = '0;
    bus.s_cti   = '0;
    bus.s_bte   = '0;
    bus.s_cyc   = 1'b0;
    bus.s_stb   = 1'b0;
    bus.s_we    = 1'b0;
    if (state_q != IDLE) bus.grant[grant_q] = 1'b1;
    if (state_q == BUSY) begin
      bus.s_adr            = bus.m_adr[grant_q];
      bus.s_dat_w          = bus.m_dat_w[grant_q];
      bus.s_sel            = bus.m_sel[grant_q];
      bus.s_cti            = bus.m_cti[grant_q];
      bus.s_bte            = bus.m_bte[grant_q];
      bus.s_cyc            = bus.m_cyc[grant_q];
      bus.s_stb            = bus.m_stb[grant_q];
      bus.s_we             = bus.m_we[grant_q];
      bus.m_ack[grant_q]   = bus.s_ack;
      bus.m_err[grant_q]   = bus.s_err;
    end
    if (evt_q) bus.m_err[grant_q] = 1'b1;
  end
  assign bus.timeout_evt = evt_q;
endmodule

// File: tb/tb_wb_arbiter_nx1.sv
// tb_wb_arbiter_nx1: directed stimulus with a response scoreboard for the Wishbone N:1 arbiter
module tb_wb_arbiter_nx1;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  typedef struct packed {
    logic [N-1:0]  grant;
    logic [N-1:0]  ack;
    logic [N-1:0]  err;
    logic          evt;
    logic [DW-1:0] dat;
  } rsp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  rsp_t exp_q[$];
  wb_arbiter_nx1_if #(.N_MASTERS(N), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW)) bus ();
  wb_arbiter_nx1_if #(.N_MASTERS(N), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW)) bus0 ();
  wb_arbiter_nx1 #(.N_MASTERS(N), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  wb_arbiter_nx1 #(.N_MASTERS(N), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [N-1:0] g, input logic [N-1:0] a, input logic [N-1:0] e,
                      input logic v, input logic [DW-1:0] d);
    rsp_t r;
    r = '{grant: g, ack: a, err: e, evt: v, dat: d};
    exp_q.push_back(r);
  endtask
  // Any forwarded response is matched against the next queued expectation.
  always @(negedge clk) begin
    rsp_t a, e;
    if (bus.m_ack != '0 || bus.m_err != '0 || bus.timeout_evt) begin
      a = '{grant: bus.grant, ack: bus.m_ack, err: bus.m_err, evt: bus.timeout_evt, dat: bus.m_dat_r};
      if (exp_q.size() == 0) chk("sb_unexpected", 64'(a), 64'(0));
      else begin
        e = exp_q.pop_front();
        chk("sb_rsp", 64'(a), 64'(e));
      end
    end
  end
  task automatic xfer(input int k);
    logic [N-1:0] g;
    g = N'(1) << k;
    chk("rr_grant", 64'(bus.grant), 64'(g));
    chk("rr_s_adr", 64'(bus.s_adr), 64'(32'h1000_0000 + 32'(k)));
    bus.s_ack   = 1'b1;
    bus.s_dat_r = 32'hD000_0000 + 32'(k);
    push(g, g, '0, 1'b0, 32'hD000_0000 + 32'(k));
    tick;
    bus.s_ack    = 1'b0;
    bus.m_cyc[k] = 1'b0;
    bus.m_stb[k] = 1'b0;
    tick;
    chk("gap_grant", 64'(bus.grant), 64'(0));
    chk("gap_s_cyc", 64'(bus.s_cyc), 64'(0));
    bus.m_cyc[k] = 1'b1;
    bus.m_stb[k] = 1'b1;
    tick;
  endtask
  initial begin
    #500000;
    $display("FAIL sim_timeout: got no finish, expected finish before 500000");
    $fatal(1);
  end
  initial begin
    logic seen;
    bus.m_dat_w = '0; bus.m_sel = '1; bus.m_cti = '0; bus.m_bte = '0;
    bus.m_cyc = '0; bus.m_stb = '0; bus.m_we = '0;
    bus.s_dat_r = '0; bus.s_ack = 1'b0; bus.s_err = 1'b0;
    for (int k = 0; k < N; k++) bus.m_adr[k] = 32'h1000_0000 + 32'(k);
    bus0.m_adr = '0; bus0.m_dat_w = '0; bus0.m_sel = '0; bus0.m_cti = '0; bus0.m_bte = '0;
    bus0.m_cyc = '0; bus0.m_stb = '0; bus0.m_we = '0;
    bus0.s_dat_r = '0; bus0.s_ack = 1'b0; bus0.s_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 64'(bus.grant), 64'(0));
    chk("rst_s_cyc", 64'(bus.s_cyc), 64'(0));
    chk("rst_evt", 64'(bus.timeout_evt), 64'(0));
    rst = 1'b0;
    bus.m_cyc = 4'b1111;
    bus.m_stb = 4'b1111;
    tick;
    chk("first_s_cyc", 64'(bus.s_cyc), 64'(1));
    xfer(0); xfer(1); xfer(2); xfer(3); xfer(0);
    bus.m_cyc = '0;
    bus.m_stb = '0;
    tick;
    tick;
    bus.m_cyc   = 4'b0100;
    bus.m_stb   = 4'b0100;
    bus.m_adr[2] = 32'h2000_0000;
    bus.m_cti[2] = 3'b010;
    tick;
    chk("burst_grant0", 64'(bus.grant), 64'(4'b0100));
    for (int b = 0; b < 4; b++) begin
      bus.m_adr[2] = 32'h2000_0000 + 32'(4 * b);
      bus.m_cti[2] = (b == 3) ? 3'b111 : 3'b010;
      bus.s_ack    = 1'b1;
      bus.s_dat_r  = 32'hB000_0000 + 32'(b);
      push(4'b0100, 4'b0100, '0, 1'b0, 32'hB000_0000 + 32'(b));
      if (b == 1) begin
        bus.m_cyc[1] = 1'b1;
        bus.m_stb[1] = 1'b1;
      end
      #1;
      chk("burst_s_adr", 64'(bus.s_adr), 64'(32'h2000_0000 + 32'(4 * b)));
      chk("burst_s_cti", 64'(bus.s_cti), 64'((b == 3) ? 3'b111 : 3'b010));
      tick;
      chk("burst_hold", 64'(bus.grant), 64'(4'b0100));
    end
    bus.s_ack    = 1'b0;
    bus.m_cyc[2] = 1'b0;
    bus.m_stb[2] = 1'b0;
    tick;
    chk("burst_idle", 64'(bus.grant), 64'(0));
    tick;
    chk("after_burst_grant", 64'(bus.grant), 64'(4'b0010));
    bus.s_ack   = 1'b1;
    bus.s_dat_r = 32'hC000_0001;
    push(4'b0010, 4'b0010, '0, 1'b0, 32'hC000_0001);
    tick;
    bus.s_ack = 1'b0;
    bus.m_cyc = '0;
    bus.m_stb = '0;
    tick;
    tick;
    bus.s_dat_r  = '0;
    bus.m_cyc[3] = 1'b1;
    bus.m_stb[3] = 1'b1;
    tick;
    chk("wd_grant", 64'(bus.grant), 64'(4'b1000));
    push(4'b1000, '0, 4'b1000, 1'b1, '0);
    repeat (7) tick;
    chk("wd_c8_evt", 64'(bus.timeout_evt), 64'(0));
    chk("wd_c8_s_cyc", 64'(bus.s_cyc), 64'(1));
    tick;
    chk("wd_c9_evt", 64'(bus.timeout_evt), 64'(1));
    chk("wd_c9_err", 64'(bus.m_err), 64'(4'b1000));
    chk("wd_c9_s_cyc", 64'(bus.s_cyc), 64'(0));
    tick;
    chk("wd_c10_evt", 64'(bus.timeout_evt), 64'(0));
    chk("wd_c10_err", 64'(bus.m_err), 64'(0));
    tick;
    tick;
    bus.s_ack = 1'b1;
    #1;
    chk("late_ack", 64'(bus.m_ack), 64'(0));
    chk("late_s_cyc", 64'(bus.s_cyc), 64'(0));
    @(negedge clk);
    bus.s_ack    = 1'b0;
    bus.m_cyc[3] = 1'b0;
    bus.m_stb[3] = 1'b0;
    tick;
    tick;
    bus.m_cyc[0] = 1'b1;
    bus.m_stb[0] = 1'b1;
    tick;
    chk("pre_rst_s_cyc", 64'(bus.s_cyc), 64'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_s_cyc", 64'(bus.s_cyc), 64'(0));
    chk("mid_rst_grant", 64'(bus.grant), 64'(0));
    bus.m_cyc = 4'b1010;
    bus.m_stb = 4'b1010;
    bus.s_ack = 1'b1;
    #1;
    chk("mid_rst_ack", 64'(bus.m_ack), 64'(0));
    bus.s_ack = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    chk("post_rst_grant", 64'(bus.grant), 64'(4'b0010));
    bus.m_cyc = '0;
    bus.m_stb = '0;
    tick;
    tick;
    bus0.m_cyc = 4'b0001;
    bus0.m_stb = 4'b0001;
    tick;
    seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick;
      seen = seen | bus0.timeout_evt | (|bus0.m_err);
    end
    chk("t0_no_abort", 64'(seen), 64'(0));
    chk("t0_grant", 64'(bus0.grant), 64'(4'b0001));
    chk("t0_s_cyc", 64'(bus0.s_cyc), 64'(1));
    @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
